// File: rtl/bus_cycle_capture_pkg.sv
// ----------------------------------------------------------------------------
// bus_capture_pkg
// Shared definitions for the bus cycle capture front end: FSM state encoding,
// record layout and flag bit positions, plus a helper that packs one record.
// ----------------------------------------------------------------------------
package bus_capture_pkg;

    localparam int REC_WIDTH = 72;
    localparam int ADDR_LSB  = 0;
    localparam int DATA_LSB  = 32;
    localparam int FLAGS_LSB = 64;

    // Bit positions inside the flags byte
    localparam int FLG_RW      = 0;
    localparam int FLG_DSACK0  = 1;
    localparam int FLG_DSACK1  = 2;
    localparam int FLG_BERR    = 3;
    localparam int FLG_TIMEOUT = 4;
    localparam int FLG_ABORT   = 5;
    localparam int FLG_OVF     = 6;
    localparam int FLG_DS      = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT_TERM,
        ST_SETTLE,
        ST_PUSH,
        ST_WAIT_END
    } cap_state_t;

    function automatic logic [REC_WIDTH-1:0] pack_record(
        input logic [7:0]  flags,
        input logic [31:0] data,
        input logic [31:0] addr
    );
        logic [REC_WIDTH-1:0] r;
        r                  = '0;
        r[ADDR_LSB  +: 32] = addr;
        r[DATA_LSB  +: 32] = data;
        r[FLAGS_LSB +: 8]  = flags;
        return r;
    endfunction

endpackage

// File: rtl/bus_cycle_capture_fifo.sv
// ----------------------------------------------------------------------------
// record_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on o_rd_data (zero while empty). A write into a full FIFO is still accepted
// when a read happens in the same cycle; o_wr_ok reports whether the write
// was taken.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset (empties the FIFO)
//   i_wr_en    write request
//   i_wr_data  write data
//   o_wr_ok    write accepted this cycle
//   i_rd_en    pop request (ignored when empty)
//   o_rd_data  head entry
//   o_empty    no entries
//   o_full     DEPTH entries
// ----------------------------------------------------------------------------
module record_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_wr_ok,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty differ
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_rd_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_ok   = i_rd_en && !o_empty;
    assign o_wr_ok   = i_wr_en && (!o_full || w_rd_ok);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (o_wr_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (o_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/bus_cycle_capture.sv
// ----------------------------------------------------------------------------
// bus_cycle_capture
// Samples an asynchronous 68030-style bus, splits every bus cycle into an
// address phase and a data phase, packs the result into a 72-bit record
// {flags, data, addr} and queues it for the serial dumper.
//
// Ports:
//   comm_clock      sole clock, rising edge
//   comm_reset_n    synchronous active-low reset
//   capture_enable  allow new cycles to start (a running cycle always finishes)
//   pin_as/ds/rw    bus strobes and direction (async, AS/DS active low)
//   pin_ad          multiplexed address/data (async)
//   pin_dsack0/1    termination acknowledges (async, active low)
//   pin_berr        bus error (async, active low)
//   rec_data        head record, first-word-fall-through
//   rec_valid       record available
//   rec_ready       consumer takes rec_data when rec_valid & rec_ready
//   overflow        sticky: a record was dropped since reset
//   busy            capture FSM is not idle
// ----------------------------------------------------------------------------
module bus_cycle_capture
    import bus_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_DELAY = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 comm_clock,
    input  logic                 comm_reset_n,
    input  logic                 capture_enable,
    input  logic                 pin_as,
    input  logic                 pin_ds,
    input  logic                 pin_rw,
    input  logic [31:0]          pin_ad,
    input  logic                 pin_dsack0,
    input  logic                 pin_dsack1,
    input  logic                 pin_berr,
    output logic [REC_WIDTH-1:0] rec_data,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic                 overflow,
    output logic                 busy
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam int SET_W = $clog2(DATA_DELAY + 1) + 1;

    // ------------------------------------------------------------------
    // Two-flop synchronizers. Control order: {as, ds, rw, dsack0, dsack1, berr}
    // ------------------------------------------------------------------
    logic [5:0]  r_ctl_s1, r_ctl_s2;
    logic [31:0] r_ad_s1,  r_ad_s2;

    always_ff @(posedge comm_clock) begin
        if (!comm_reset_n) begin
            r_ctl_s1 <= '1;
            r_ctl_s2 <= '1;
            r_ad_s1  <= '1;
            r_ad_s2  <= '1;
        end else begin
            r_ctl_s1 <= {pin_as, pin_ds, pin_rw, pin_dsack0, pin_dsack1, pin_berr};
            r_ctl_s2 <= r_ctl_s1;
            r_ad_s1  <= pin_ad;
            r_ad_s2  <= r_ad_s1;
        end
    end

    logic w_as_s, w_ds_s, w_rw_s, w_dsack0_s, w_dsack1_s, w_berr_s;
    assign {w_as_s, w_ds_s, w_rw_s, w_dsack0_s, w_dsack1_s, w_berr_s} = r_ctl_s2;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    cap_state_t       r_state;
    logic             r_as_prev;
    logic [31:0]      r_addr, r_data;
    logic             r_rw, r_f_dsack0, r_f_dsack1, r_f_berr, r_f_ds;
    logic             r_timeout, r_aborted, r_pend_ovf, r_overflow;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [SET_W-1:0] r_set_cnt;

    logic                 w_term, w_settle_last, w_push, w_wr_ok, w_empty, w_full;
    logic [7:0]           w_flags;
    logic [REC_WIDTH-1:0] w_record;

    assign w_term        = !w_dsack0_s || !w_dsack1_s || !w_berr_s;
    assign w_settle_last = (int'(r_set_cnt) + 1) >= DATA_DELAY;
    assign w_push        = (r_state == ST_PUSH);

    always_ff @(posedge comm_clock) begin
        if (!comm_reset_n) begin
            r_state    <= ST_IDLE;
            r_as_prev  <= 1'b1;
            r_addr     <= '0;
            r_data     <= '0;
            r_rw       <= 1'b0;
            r_f_dsack0 <= 1'b0;
            r_f_dsack1 <= 1'b0;
            r_f_berr   <= 1'b0;
            r_f_ds     <= 1'b0;
            r_timeout  <= 1'b0;
            r_aborted  <= 1'b0;
            r_pend_ovf <= 1'b0;
            r_overflow <= 1'b0;
            r_tmo_cnt  <= '0;
            r_set_cnt  <= '0;
        end else begin
            r_as_prev <= w_as_s;
            case (r_state)
                ST_IDLE: begin
                    if (r_as_prev && !w_as_s && capture_enable)
                        r_state <= ST_ADDR;
                end
                ST_ADDR: begin
                    r_addr     <= r_ad_s2;
                    r_rw       <= w_rw_s;
                    r_data     <= '0;
                    r_f_dsack0 <= 1'b0;
                    r_f_dsack1 <= 1'b0;
                    r_f_berr   <= 1'b0;
                    r_f_ds     <= 1'b0;
                    r_timeout  <= 1'b0;
                    r_aborted  <= 1'b0;
                    r_tmo_cnt  <= '0;
                    r_state    <= ST_WAIT_TERM;
                end
                ST_WAIT_TERM: begin
                    // Termination beats abort beats timeout
                    if (w_term) begin
                        r_f_dsack0 <= !w_dsack0_s;
                        r_f_dsack1 <= !w_dsack1_s;
                        r_f_berr   <= !w_berr_s;
                        r_f_ds     <= !w_ds_s;
                        r_set_cnt  <= '0;
                        r_state    <= ST_SETTLE;
                    end else if (w_as_s) begin
                        r_aborted <= 1'b1;
                        r_state   <= ST_PUSH;
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_PUSH;
                    end else if (r_tmo_cnt != {TMO_W{1'b1}}) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Let AD settle after termination before sampling data
                    if (w_settle_last) begin
                        r_data  <= r_ad_s2;
                        r_state <= ST_PUSH;
                    end else begin
                        r_set_cnt <= r_set_cnt + 1'b1;
                    end
                end
                ST_PUSH: begin
                    if (w_wr_ok) begin
                        r_pend_ovf <= 1'b0;
                    end else begin
                        r_overflow <= 1'b1;
                        r_pend_ovf <= 1'b1;
                    end
                    // An aborted cycle already saw AS high, nothing to wait for
                    r_state <= r_aborted ? ST_IDLE : ST_WAIT_END;
                end
                ST_WAIT_END: begin
                    if (w_as_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_flags              = '0;
        w_flags[FLG_RW]      = r_rw;
        w_flags[FLG_DSACK0]  = r_f_dsack0;
        w_flags[FLG_DSACK1]  = r_f_dsack1;
        w_flags[FLG_BERR]    = r_f_berr;
        w_flags[FLG_TIMEOUT] = r_timeout;
        w_flags[FLG_ABORT]   = r_aborted;
        w_flags[FLG_OVF]     = r_pend_ovf;
        w_flags[FLG_DS]      = r_f_ds;
        w_record             = pack_record(w_flags, r_data, r_addr);
    end

    // ------------------------------------------------------------------
    // Record buffer
    // ------------------------------------------------------------------
    record_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (comm_clock),
        .rst_n     (comm_reset_n),
        .i_wr_en   (w_push),
        .i_wr_data (w_record),
        .o_wr_ok   (w_wr_ok),
        .i_rd_en   (rec_ready),
        .o_rd_data (rec_data),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    assign rec_valid = !w_empty;
    assign overflow  = r_overflow;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/bus_cycle_capture.md
# bus_cycle_capture

Front-end capture stage for the serial bus debugger. Samples the asynchronous 68030-style bus (AS, DS, R/W, multiplexed AD, DSACK0/1, BERR) in the comm clock domain and splits each bus cycle into an address phase and a data phase. It packs each completed cycle into a 72-bit record and buffers records in a small FIFO. The serial dumper downstream drains that FIFO through a valid/ready handshake.

## Interface

Parameters:
- FIFO_DEPTH, 16, record slots; power of two, 2..256.
- DATA_DELAY, 2, comm_clock cycles between synchronized termination and data sampling (AD settle).
- TIMEOUT, 4096, comm_clock cycles from address latch to forced timeout record.

Ports:
- comm_clock  in  1  sole clock (16 MHz); all logic on rising edge.
- comm_reset_n  in  1  synchronous, active-low reset.
- capture_enable  in  1  high = capture new cycles; low = finish current cycle, start no new one.
- pin_as  in  1  address strobe, active low, async.
- pin_ds  in  1  data strobe, active low, async; recorded only.
- pin_rw  in  1  1 = read, 0 = write, async.
- pin_ad  in  32  multiplexed address/data, async.
- pin_dsack0  in  1  active low, async.
- pin_dsack1  in  1  active low, async.
- pin_berr  in  1  active low, async.
- rec_data  out  72  {flags[7:0], data[31:0], addr[31:0]}.
- rec_valid  out  1  FIFO non-empty.
- rec_ready  in  1  consumer accepts rec_data when rec_valid & rec_ready.
- overflow  out  1  sticky; a record was dropped since reset.
- busy  out  1  FSM not in IDLE.

## Operation

- Synchronizers: every bus input passes through 2 flops. pin_ad is also 2-flop sampled (bus-stable windows only). The FSM sees only synchronized signals.
- Flags byte:
  - [0] rw
  - [1] ~dsack0
  - [2] ~dsack1
  - [3] ~berr
  - [4] timeout
  - [5] aborted (AS rose before termination)
  - [6] overflow-since-last-record
  - [7] ~ds at termination
- FSM states: IDLE, ADDR, WAIT_TERM, SETTLE, PUSH, WAIT_END.
  - IDLE: on as_s falling edge (prev 1, now 0) and capture_enable=1, go to ADDR.
  - ADDR: latch addr=ad_s, rw=rw_s, clear timeout counter; go to WAIT_TERM.
  - WAIT_TERM, first matching rule wins:
    - dsack0_s=0, dsack1_s=0 or berr_s=0: latch termination flags, go to SETTLE.
    - as_s=1: set aborted, data=0, go to PUSH.
    - counter = TIMEOUT-1: set timeout, data=0, go to PUSH.
  - SETTLE: count DATA_DELAY cycles, latch data=ad_s, go to PUSH.
  - PUSH: one cycle; write record if FIFO not full, else drop it and set overflow plus the pending-overflow bit. Then go to WAIT_END, or IDLE if aborted.
  - WAIT_END: wait for as_s=1, then IDLE. This covers timeout records where AS is still low.
- Pending-overflow bit: goes into flags[6] of the next successfully pushed record, then clears.
- Timeout counter: $clog2(TIMEOUT)+1 bits, saturating; no wrap.
- FIFO:
  - Read and write pointers are one bit wider than the address, so full and empty are distinguishable.
  - Push and pop in the same cycle are both accepted when full; no overflow occurs.
  - Pop when empty is ignored.
  - rec_data is first-word-fall-through.
- capture_enable falling mid-cycle: the current cycle completes normally.

## Timing

- Reset values (comm_reset_n=0 for one edge): FSM IDLE, FIFO empty, rec_valid=0, rec_data=0, overflow=0, busy=0, pending-overflow=0, synchronizer flops 1 (bus idle-high). Reset takes effect mid-cycle or mid-transfer; the partial record is discarded.
- AS edge to ADDR state: 3 cycles (2 sync + edge detect).
- DSACK edge to FIFO write: 2 sync + 1 detect + DATA_DELAY + 1 PUSH.
- PUSH to rec_valid (empty FIFO): rec_valid high the next cycle.
- Throughput: one record per bus cycle. A new AS fall is not recognized until after WAIT_END exits.
- Minimum: AS high must last 2 comm_clock cycles to be seen as a new cycle.

## Structure

- Package bus_capture_pkg:
  - state enum;
  - flag bit index constants;
  - REC_WIDTH=72;
  - field offsets ADDR_LSB=0, DATA_LSB=32, FLAGS_LSB=64.
- Sub-module record_fifo: parameterized width and depth, synchronous, FWFT. It is reused by the serial dumper's command path.

## Test plan

- Read cycle: AS low, AD=0x0000_1234, then AD=0xCAFEBABE, DSACK0=DSACK1=0, rw=1 → one record: addr 0x00001234, data 0xCAFEBABE, flags 0x87.
- BERR cycle: write to 0x00FF_0000, BERR low with no DSACK, DS high → data sampled, flags 0x08.
- Timeout: TIMEOUT=64, AS held low for 200 cycles with no termination → one record, flags bit4 set, data 0; no second record until AS rises and falls.
- Abort: AS rises before any DSACK → flags bit5 set; FSM in IDLE 1 cycle after PUSH.
- Overflow: FIFO_DEPTH=4, rec_ready=0, 6 bus cycles → 4 records stored, overflow=1. Then drain; on the next cycle the record has flags bit6=1, and the record after it has bit6=0.
- Reset mid-SETTLE and simultaneous push/pop on a full FIFO → reset leaves everything empty and IDLE; the push/pop case keeps count at 4 with no overflow.
